// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU result serializer.
// Source priority lives here so every consumer agrees on it.
package alu_pkg;

    localparam int DEF_IN_WIDTH   = 16;
    localparam int DEF_BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_ARITH = 2'd0,
        SRC_LOGIC = 2'd1,
        SRC_CMP   = 2'd2,
        SRC_SHIFT = 2'd3
    } src_t;

    // flags = {shift, cmp, logic, arith}; arith wins
    function automatic src_t pick_src(input logic [3:0] flags);
        if (flags[0])      return SRC_ARITH;
        else if (flags[1]) return SRC_LOGIC;
        else if (flags[2]) return SRC_CMP;
        else               return SRC_SHIFT;
    endfunction

endpackage

// File: rtl/alu_result_serializer_flag_edge.sv
// Rising-edge detect on the OR of the unit flags, plus multi-flag detect.
// A flag held high yields one capture pulse per assertion.
module alu_flag_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] flags,
    output logic       capture,
    output logic       multi
);

    logic any_flag;
    logic any_flag_d;

    assign any_flag = |flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_flag_d <= 1'b0;
        end else begin
            any_flag_d <= any_flag;
        end
    end

    assign capture = any_flag & ~any_flag_d;
    // x & (x-1) is nonzero iff two or more bits are set
    assign multi   = capture & (|(flags & (flags - 4'd1)));

endmodule

// File: rtl/alu_result_serializer.sv
// Captures one ALU unit result per flag assertion and streams it
// low byte first over a valid/ready handshake.
module alu_result_serializer
    import alu_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [IN_WIDTH-1:0]   Arith_OUT,
    input  logic [IN_WIDTH-1:0]   Logic_OUT,
    input  logic [IN_WIDTH-1:0]   CMP_OUT,
    input  logic [IN_WIDTH-1:0]   SHIFT_OUT,
    input  logic                  Arith_Flag,
    input  logic                  Logic_Flag,
    input  logic                  CMP_Flag,
    input  logic                  SHIFT_Flag,
    input  logic                  TX_READY,
    output logic [BYTE_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    output logic                  Busy,
    output logic                  Multi_Err,
    output logic                  Overrun
);

    logic [3:0]            flags;
    logic                  capture;
    logic                  multi;
    src_t                  src;
    logic [IN_WIDTH-1:0]   sel_res;
    logic                  hs;

    state_t                state;
    state_t                state_nx;
    logic [IN_WIDTH-1:0]   res_reg;
    logic [IN_WIDTH-1:0]   res_nx;
    logic                  overrun_nx;
    logic [BYTE_WIDTH-1:0] data_nx;
    logic                  valid_nx;

    assign flags = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    assign src   = pick_src(flags);
    assign hs    = TX_VALID & TX_READY;

    alu_flag_edge u_flag_edge (
        .clk     (CLK),
        .rst_n   (RST),
        .flags   (flags),
        .capture (capture),
        .multi   (multi)
    );

    always_comb begin
        sel_res = '0;
        unique case (src)
            SRC_ARITH: sel_res = Arith_OUT;
            SRC_LOGIC: sel_res = Logic_OUT;
            SRC_CMP:   sel_res = CMP_OUT;
            SRC_SHIFT: sel_res = SHIFT_OUT;
            default:   sel_res = '0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        res_nx     = res_reg;
        overrun_nx = Overrun;
        data_nx    = '0;
        valid_nx   = 1'b0;

        unique case (state)
            IDLE: begin
                if (capture) begin
                    res_nx   = sel_res;
                    state_nx = SEND_LO;
                end
            end
            SEND_LO: begin
                if (hs)      state_nx   = SEND_HI;
                if (capture) overrun_nx = 1'b1;
            end
            SEND_HI: begin
                // a capture on the final handshake edge chains directly
                if (hs && capture) begin
                    res_nx   = sel_res;
                    state_nx = SEND_LO;
                end else if (hs) begin
                    state_nx = IDLE;
                end else if (capture) begin
                    overrun_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        unique case (state_nx)
            SEND_LO: begin
                data_nx  = res_nx[BYTE_WIDTH-1:0];
                valid_nx = 1'b1;
            end
            SEND_HI: begin
                data_nx  = res_nx[IN_WIDTH-1:BYTE_WIDTH];
                valid_nx = 1'b1;
            end
            default: begin
                data_nx  = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            res_reg   <= '0;
            TX_DATA   <= '0;
            TX_VALID  <= 1'b0;
            Busy      <= 1'b0;
            Multi_Err <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            res_reg   <= res_nx;
            TX_DATA   <= data_nx;
            TX_VALID  <= valid_nx;
            Busy      <= (state_nx != IDLE);
            Multi_Err <= multi;
            Overrun   <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench: vector table plus byte scoreboard and
// hand-written stall, back-to-back, overrun and reset sequences.
module tb_alu_result_serializer;

    logic        CLK;
    logic        RST;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
    logic        TX_READY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID, Busy, Multi_Err, Overrun;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    alu_result_serializer #(.IN_WIDTH(16), .BYTE_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
        .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
        .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
        .TX_READY(TX_READY), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .Busy(Busy), .Multi_Err(Multi_Err), .Overrun(Overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  flags;  // {shift, cmp, logic, arith}
        logic [15:0] a, l, c, s;
        int          hold;
        logic        multi;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = f;
    endtask

    task automatic push(input logic [15:0] v);
        sb.push_back(v[7:0]);
        sb.push_back(v[15:8]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (Busy && n < 12) begin
            tick();
            n++;
        end
        check(name, {15'd0, Busy}, 16'd0);
    endtask

    // a byte transfers on the next rising edge if valid & ready now
    always @(negedge CLK) begin
        if (RST && TX_VALID && TX_READY) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%h required=none", TX_DATA);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (TX_DATA !== e) begin
                    failures++;
                    $display("FAIL sb_byte actual=%h required=%h", TX_DATA, e);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{4'b0010, 16'h0000, 16'hA5C3, 16'h0000, 16'h0000, 4, 1'b0, 16'hA5C3};
        vecs[1] = '{4'b0101, 16'h1234, 16'h0000, 16'h0001, 16'h0000, 1, 1'b1, 16'h1234};
        vecs[2] = '{4'b1111, 16'h4321, 16'h1111, 16'h2222, 16'h3333, 2, 1'b1, 16'h4321};
        vecs[3] = '{4'b1010, 16'h0000, 16'h6E6E, 16'h0000, 16'h9999, 1, 1'b1, 16'h6E6E};
        vecs[4] = '{4'b1000, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 3, 1'b0, 16'h8001};
        vecs[5] = '{4'b0100, 16'h0000, 16'h0000, 16'h7F80, 16'h0000, 1, 1'b0, 16'h7F80};

        RST = 1'b0;
        TX_READY = 1'b0;
        Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; SHIFT_OUT = '0;
        set_flags(4'b0000);
        tick();
        tick();
        check("rst_data",  {8'd0, TX_DATA}, 16'd0);
        check("rst_valid", {15'd0, TX_VALID}, 16'd0);
        check("rst_busy",  {15'd0, Busy}, 16'd0);
        check("rst_multi", {15'd0, Multi_Err}, 16'd0);
        check("rst_ovr",   {15'd0, Overrun}, 16'd0);
        RST = 1'b1;
        TX_READY = 1'b1;
        tick();

        foreach (vecs[i]) begin
            int last;
            Arith_OUT = vecs[i].a; Logic_OUT = vecs[i].l;
            CMP_OUT = vecs[i].c;   SHIFT_OUT = vecs[i].s;
            set_flags(vecs[i].flags);
            push(vecs[i].exp);
            last = (vecs[i].hold > 3 ? vecs[i].hold : 3) + 1;
            for (int k = 1; k <= last; k++) begin
                tick();
                if (k == vecs[i].hold) set_flags(4'b0000);
                if (k == 1) begin
                    check("vec_multi", {15'd0, Multi_Err}, {15'd0, vecs[i].multi});
                    check("vec_lo", {8'd0, TX_DATA}, {8'd0, vecs[i].exp[7:0]});
                end
                if (k == 2) begin
                    check("vec_multi_pulse", {15'd0, Multi_Err}, 16'd0);
                    check("vec_hi", {8'd0, TX_DATA}, {8'd0, vecs[i].exp[15:8]});
                end
                if (k >= 3) check("vec_idle", {15'd0, Busy}, 16'd0);
            end
        end

        // stall in SEND_LO
        TX_READY = 1'b0;
        Arith_OUT = 16'hBEEF;
        Arith_Flag = 1'b1;
        push(16'hBEEF);
        tick();
        Arith_Flag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_data", {8'd0, TX_DATA}, 16'h00EF);
            check("stall_valid", {15'd0, TX_VALID}, 16'd1);
        end
        TX_READY = 1'b1;
        tick();
        check("stall_hi", {8'd0, TX_DATA}, 16'h00BE);
        wait_idle("stall_idle");

        // new flag on the SEND_HI handshake edge
        Arith_OUT = 16'h5A3C;
        Arith_Flag = 1'b1;
        push(16'h5A3C);
        tick();
        Arith_Flag = 1'b0;
        tick();
        Logic_OUT = 16'h00FF;
        Logic_Flag = 1'b1;
        push(16'h00FF);
        tick();
        Logic_Flag = 1'b0;
        check("b2b_busy", {15'd0, Busy}, 16'd1);
        check("b2b_lo", {8'd0, TX_DATA}, 16'h00FF);
        check("b2b_ovr", {15'd0, Overrun}, 16'd0);
        tick();
        check("b2b_hi", {8'd0, TX_DATA}, 16'h0000);
        wait_idle("b2b_idle");
        check("b2b_ovr_end", {15'd0, Overrun}, 16'd0);

        // overrun: second flag during SEND_LO is dropped
        TX_READY = 1'b0;
        SHIFT_OUT = 16'h1177;
        SHIFT_Flag = 1'b1;
        push(16'h1177);
        tick();
        SHIFT_Flag = 1'b0;
        tick();
        SHIFT_OUT = 16'h2288;
        SHIFT_Flag = 1'b1;
        tick();
        SHIFT_Flag = 1'b0;
        check("ovr_set", {15'd0, Overrun}, 16'd1);
        check("ovr_data", {8'd0, TX_DATA}, 16'h0077);
        TX_READY = 1'b1;
        tick();
        check("ovr_hi", {8'd0, TX_DATA}, 16'h0011);
        wait_idle("ovr_idle");
        tick();
        check("ovr_sticky", {15'd0, Overrun}, 16'd1);

        // reset during SEND_HI, flag held across release
        Arith_OUT = 16'hCAFE;
        Arith_Flag = 1'b1;
        push(16'hCAFE);
        tick();
        tick();
        check("rst2_hi", {8'd0, TX_DATA}, 16'h00CA);
        TX_READY = 1'b0;
        RST = 1'b0;
        tick();
        check("rst2_data",  {8'd0, TX_DATA}, 16'd0);
        check("rst2_valid", {15'd0, TX_VALID}, 16'd0);
        check("rst2_busy",  {15'd0, Busy}, 16'd0);
        check("rst2_ovr",   {15'd0, Overrun}, 16'd0);
        sb.delete();
        RST = 1'b1;
        TX_READY = 1'b1;
        push(16'hCAFE);
        tick();
        check("rel_valid", {15'd0, TX_VALID}, 16'd1);
        check("rel_lo", {8'd0, TX_DATA}, 16'h00FE);
        Arith_Flag = 1'b0;
        wait_idle("rel_idle");
        tick();

        check("sb_empty", sb.size()[15:0], 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
